// File: rtl/div_seq_if.sv
// Request/result bundle between the EX stage and the div_seq multi-cycle divider.
// Carries the operands, the start/annul controls, the registered result and an FSM debug tap.
interface div_seq_if;
    // Handshake: EX raises start_i with stable operands and keeps it high until it
    // consumes result_o. That happens in the first cycle ready_o=1, or later while start_i
    // stays high. Dropping start_i releases the divider, which clears ready_o/result_o on
    // the next edge. annul_i cancels an in-flight division and leaves ready_o low.
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic [1:0]  state_dbg;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, state_dbg
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, state_dbg
    );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring DIV/DIVU sequencer, one quotient bit per cycle, result {rem, quot}.
// Optional macro DIV_EARLY_OUT_EN: skip the iterations when |dividend| < |divisor|.
module div_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic      clk,
    input  logic      rst,
    div_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   dq_q, dq_d;     // dividend bits shift out of the MSB, quotient bits shift in at the LSB
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   dvs_q, dvs_d;
    logic                q_neg_q, q_neg_d;
    logic                r_neg_q, r_neg_d;
    logic [2*DATA_W-1:0] result_q, result_d;
    logic                ready_q, ready_d;

    logic                a_neg, b_neg;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic                div_zero;
    logic                accept;
    logic [DATA_W:0]     trial;
    logic                q_bit;
    logic [DATA_W-1:0]   rem_step, dq_step;
    logic [DATA_W-1:0]   quot_fix, rem_fix;
    logic                last_iter;

`ifdef DIV_EARLY_OUT_EN
    logic                early;
    logic [2*DATA_W-1:0] short_res_q, short_res_d;
`endif

    // Operand conditioning and one restoring step, shared by the FSM and datapath.
    always_comb begin
        a_neg    = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
        b_neg    = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
        a_abs    = a_neg ? -bus.opdata1_i : bus.opdata1_i;
        b_abs    = b_neg ? -bus.opdata2_i : bus.opdata2_i;
        div_zero = (bus.opdata2_i == '0);
        accept   = bus.start_i & ~bus.annul_i;
`ifdef DIV_EARLY_OUT_EN
        early    = (a_abs < b_abs);
`endif
        trial     = {rem_q, dq_q[DATA_W-1]} - {1'b0, dvs_q};
        q_bit     = ~trial[DATA_W];
        rem_step  = q_bit ? trial[DATA_W-1:0] : {rem_q[DATA_W-2:0], dq_q[DATA_W-1]};
        dq_step   = {dq_q[DATA_W-2:0], q_bit};
        quot_fix  = q_neg_q ? -dq_step : dq_step;
        rem_fix   = r_neg_q ? -rem_step : rem_step;
        last_iter = (cnt_q == CNT_W'(DATA_W - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (div_zero) state_d = BYZERO;
`ifdef DIV_EARLY_OUT_EN
                    else if (early) state_d = BYZERO;
`endif
                    else state_d = ON;
                end
            end
            // BYZERO is also the one-cycle latch stage for early-out results.
            BYZERO: state_d = END;
            ON: begin
                if (bus.annul_i)    state_d = IDLE;
                else if (last_iter) state_d = END;
            end
            END: begin
                if (!bus.start_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next-value logic
    always_comb begin
        cnt_d   = cnt_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
`ifdef DIV_EARLY_OUT_EN
        short_res_d = short_res_q;
`endif
        ready_d  = (state_d == END);
        result_d = '0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d   = '0;
                    dq_d    = a_abs;
                    rem_d   = '0;
                    dvs_d   = b_abs;
                    q_neg_d = a_neg ^ b_neg;
                    r_neg_d = a_neg;
`ifdef DIV_EARLY_OUT_EN
                    short_res_d = (!div_zero && early) ? {bus.opdata1_i, {DATA_W{1'b0}}} : '0;
`endif
                end
            end
            BYZERO: begin
`ifdef DIV_EARLY_OUT_EN
                result_d = short_res_q;
`else
                result_d = '0;
`endif
            end
            ON: begin
                cnt_d = cnt_q + 1'b1;
                dq_d  = dq_step;
                rem_d = rem_step;
                if (!bus.annul_i && last_iter) result_d = {rem_fix, quot_fix};
            end
            END: begin
                if (bus.start_i) result_d = result_q;
            end
            default: result_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            dq_q     <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dq_q     <= dq_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

`ifdef DIV_EARLY_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) short_res_q <= '0;
        else     short_res_q <= short_res_d;
    end
`endif

    assign bus.result_o  = result_q;
    assign bus.ready_o   = ready_q;
    assign bus.state_dbg = state_q;

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for 32-bit DIV/DIVU issued from the EX stage.
- EX raises start_i with both operands. The block runs a radix-2 restoring division, one quotient bit per cycle. It then returns {remainder, quotient} for the HI/LO write, with a ready handshake.
- EX holds its pipeline stall request while start_i=1 and ready_o=0.

Parameters:
- DATA_W, 32, operand width. The only supported value is 32.
- CNT_W, 6, iteration counter width. Must hold the value DATA_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request division. Held high by EX until it consumes the result.
- annul_i  in  1  cancel the in-flight division (branch/exception flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}, registered
- ready_o  out  1  result_o valid, registered

Behaviour:
- Reset: rst is synchronous, active-high.
  - On reset: state=IDLE, counter=0, result_o=0, ready_o=0.
  - Reset mid-operation abandons the division immediately.
- States: IDLE, BYZERO, ON, END (2-bit encoding).
- IDLE:
  - ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0:
    - Divisor==0: go to BYZERO.
    - Otherwise: latch |dividend| and |divisor| (negate an operand only when signed_div_i=1 and its bit31=1), latch the sign flags, clear counter, go to ON.
  - start_i=1 with annul_i=1: stay IDLE.
- BYZERO: unconditionally go to END. Latched result = 0.
- ON:
  - Each cycle: shift partial remainder left 1 and bring in the next dividend MSB. Trial-subtract |divisor|; if no borrow, keep the difference and set the quotient bit = 1, else restore and set it = 0. Increment counter.
  - Annul: annul_i=1 in any ON cycle goes to IDLE with outputs 0, and no result is produced.
  - Completion: when counter reaches 32, apply sign correction and go to END.
    - Quotient is negated if signed_div_i=1 and the dividend/divisor signs differ.
    - Remainder is negated if signed_div_i=1 and the dividend is negative.
  - Width rule: all arithmetic is modulo 2^32. Signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
  - start_i and operand changes are ignored while in ON.
- END:
  - ready_o=1, result_o holds the latched value.
  - Stays in END while start_i=1.
  - start_i=0 returns to IDLE: ready_o and result_o clear on the next edge.
  - annul_i is ignored in END.
- Latency: start_i is sampled at the edge ending cycle 0.
  - Normal division: ON occupies cycles 1..32, ready_o=1 from cycle 33.
  - Divide by zero: ready_o=1 from cycle 2.
- Back-to-back: a new division needs start_i low for at least one cycle (END→IDLE). The earliest re-accept is the edge ending the IDLE cycle.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE, if the divisor is nonzero and |dividend| < |divisor| (unsigned compare of the absolute values), go directly to END with quotient 0 and remainder = the original signed dividend. ready_o=1 from cycle 2.
- Not defined: such operations take the full 32-iteration path, ready_o=1 at cycle 33, with an identical numeric result.

Test Plan:
- DIVU 100/7, start held → ready_o rises exactly at cycle 33, result_o=0x00000002_0000000E. Drop start_i → ready_o=0 and result_o=0 one cycle later.
- DIV 0xFFFFFFF9 (-7) / 2 → result_o=0xFFFFFFFF_FFFFFFFD (rem -1, quot -3). DIV 7 / 0xFFFFFFFE → 0x00000001_FFFFFFFD.
- DIVU 1234/0 → ready_o=1 at cycle 2, result_o=0. DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000.
- DIVU 1000/3, annul_i pulsed at cycle 10 → state IDLE at cycle 11, ready_o never asserts. A following DIVU 9/3 → ready at its cycle 33, result 0x00000000_00000003.
- rst asserted at cycle 5 of a division → next cycle all outputs 0, state IDLE. start_i with annul_i=1 in IDLE → no transition.
- DIVU 5/9 → result 0x00000005_00000000. ready_o at cycle 2 with DIV_EARLY_OUT_EN defined, at cycle 33 without it.
